pe_multi_ch: RTL and testbench
==============================

PE_MULTI_CH -- requirements
Module: pe_multi_ch

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of input channels, each with its own filter and accumulator.
REQ-002 SHALL have parameter DW, default 8, meaning pixel/weight width.
REQ-003 SHALL have parameter KDEPTH, default 16, meaning filter entries per channel; KW = clog2(KDEPTH).
REQ-004 SHALL have parameter ACCW, default 20, meaning per-channel accumulator width.
REQ-005 SHALL have parameter OSHIFT, default 4, meaning right shift applied to the channel sum before output.
REQ-006 SHALL have ports:
clk  in  1  sole clock, rising edge.
rst  in  1  asynchronous, active-low reset.
flt_we  in  CH  per-channel filter write enable.
flt_addr  in  KW  filter write address.
flt_data  in  DW  filter write data.
klen  in  KW+1  active filter length; 0 or >KDEPTH means KDEPTH.
start  in  1  begin one window computation.
win_valid  in  1  window beat valid.
win_data  in  CH*DW  one pixel per channel; channel c in bits [c*DW +: DW].
win_ready  out  1  window beat accepted when high with win_valid.
out_valid  out  1  result valid.
out_data  out  DW  result.
out_ready  in  1  result consumed when high with out_valid.
busy  out  1  high in any state other than IDLE.

Function
REQ-007 SHALL implement FSM IDLE -> MAC -> SUM -> OUT -> IDLE.
REQ-008 IDLE: flt_we[c] SHALL write flt_data to filter c at flt_addr on the clock edge; flt_we SHALL be ignored in all other states.
REQ-009 IDLE: start SHALL latch klen, clear the beat counter k and all accumulators, and enter MAC; start SHALL be ignored outside IDLE.
REQ-010 MAC: win_ready SHALL be 1; win_ready SHALL be 0 in all other states.
REQ-011 MAC: each accepted beat SHALL add the unsigned 2*DW product win_data[c]*filter[c][k] to acc[c] for every c, then increment k.
REQ-012 A win_valid gap SHALL stall the counter and accumulators without penalty.
REQ-013 Accumulators SHALL wrap modulo 2^ACCW.
REQ-014 The accept of beat number klen (k = klen-1) SHALL transition MAC to SUM.
REQ-015 SUM SHALL last exactly one cycle and compute total = sum of all acc[c] at width ACCW+clog2(CH) with no overflow, then shifted = total >> OSHIFT.
REQ-016 SUM SHALL register out_data from shifted per REQ-022 and assert out_valid in the next cycle (OUT).
REQ-017 Latency SHALL be 2 cycles from the last accepted beat to out_valid high.
REQ-018 OUT: out_valid and out_data SHALL hold stable until out_ready is 1; on that edge the FSM SHALL go to IDLE and out_valid SHALL drop.
REQ-019 IDLE with start high in the same cycle as the OUT handshake: start SHALL be ignored (FSM still in OUT).

Reset
REQ-020 rst low SHALL immediately, without waiting for a clock edge, force the following:
- FSM to IDLE.
- k, all accumulators, and all filter entries to 0.
- out_valid, out_data, win_ready and busy to 0.
REQ-021 A reset asserted mid-MAC or mid-OUT SHALL discard the operation; the first start after reset release SHALL behave as a fresh operation.

Configuration
REQ-022 Macro PE_SAT_OUT_EN SHALL control output width reduction:
- Defined: out_data = min(shifted, 2^DW-1).
- Undefined: out_data = shifted[DW-1:0] (truncation, wrap).

Verification (CH=4, DW=8, KDEPTH=16, ACCW=20, OSHIFT=4)
REQ-023 All filters=1, win_data all bytes=2, klen=0, 16 back-to-back beats -> out_data=8, out_valid exactly 2 cycles after the last beat.
REQ-024 All filters=255, all pixels=255, klen=16 -> out_data=255 with PE_SAT_OUT_EN, out_data=4 without.
REQ-025 klen=1, filter[c][0]=c+1, pixels=10 -> one beat accepted, out_data=6; extra win_valid beats not accepted (win_ready=0).
REQ-026 out_ready held 0 for 5 cycles in OUT, with start and flt_we pulsed -> out_data stable, filters unchanged, no new operation; out_ready=1 -> IDLE next cycle.
REQ-027 Random win_valid gaps in scenario REQ-023 -> same result 8; rst low after 7 beats -> all outputs 0 asynchronously; after release, start with no reload -> out_data=0.

Source files
------------

// File: rtl/pe_multi_ch.sv
// pe_multi_ch -- multi-channel processing element.
//
// Each of CH channels owns a KDEPTH-entry filter and an ACCW-bit accumulator.
// One operation streams klen window beats. Every accepted beat multiplies one
// pixel per channel by that channel's filter entry k and accumulates the
// product. Afterwards the channel accumulators are summed, shifted right by
// OSHIFT, reduced to DW bits and presented on a valid/ready output.
//
// Optional feature macro: PE_SAT_OUT_EN
//   defined   -> out_data saturates to 2^DW-1
//   undefined -> out_data is the low DW bits of the shifted sum (wraps)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-low reset
//   flt_we     per-channel filter write enable (honoured in IDLE only)
//   flt_addr   filter write address
//   flt_data   filter write data
//   klen       active filter length; 0 or >KDEPTH means KDEPTH
//   start      begin one window computation (honoured in IDLE only)
//   win_valid  window beat valid
//   win_data   one pixel per channel, channel c in [c*DW +: DW]
//   win_ready  beat accepted when high together with win_valid
//   out_valid  result valid
//   out_data   result
//   out_ready  result consumed when high together with out_valid
//   busy       high whenever the FSM is not in IDLE

// Per-channel lane: filter storage plus multiply-accumulate.
module pe_lane #(
  parameter int DW     = 8,
  parameter int KDEPTH = 16,
  parameter int KW     = 4,
  parameter int ACCW   = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [KW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic            clr,
  input  logic            en,
  input  logic [KW-1:0]   k,
  input  logic [DW-1:0]   pix,
  output logic [ACCW-1:0] acc
);
  logic [KDEPTH-1:0][DW-1:0] flt;
  logic [2*DW-1:0]           prod;

  // Operands zero-extended so the product is computed at full 2*DW width.
  assign prod = {{DW{1'b0}}, pix} * {{DW{1'b0}}, flt[k]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flt <= '0;
      acc <= '0;
    end else begin
      if (we) flt[waddr] <= wdata;
      if (clr)     acc <= '0;
      else if (en) acc <= acc + ACCW'(prod);  // wraps modulo 2^ACCW
    end
  end
endmodule

module pe_multi_ch #(
  parameter int CH     = 4,
  parameter int DW     = 8,
  parameter int KDEPTH = 16,
  parameter int ACCW   = 20,
  parameter int OSHIFT = 4,
  localparam int KW    = $clog2(KDEPTH),
  localparam int TW    = ACCW + $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   flt_we,
  input  logic [KW-1:0]   flt_addr,
  input  logic [DW-1:0]   flt_data,
  input  logic [KW:0]     klen,
  input  logic            start,
  input  logic            win_valid,
  input  logic [CH*DW-1:0] win_data,
  output logic            win_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  input  logic            out_ready,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, MAC, SUM, OUT} state_t;

  state_t                    state, nxt;
  logic [KW-1:0]             k, last_k, klen_last;
  logic                      clr, en, idle;
  logic [CH-1:0][DW-1:0]     pix;
  logic [CH-1:0][ACCW-1:0]   acc;
  logic [TW-1:0]             total;
  logic [DW-1:0]             res;

  assign idle      = (state == IDLE);
  assign busy      = !idle;
  assign win_ready = (state == MAC);
  assign out_valid = (state == OUT);
  assign pix       = win_data;

  // Store the index of the final beat rather than the length, so the
  // KDEPTH case still fits in KW bits.
  assign klen_last = (klen == '0 || 32'(klen) > KDEPTH) ? KW'(KDEPTH - 1)
                                                         : KW'(klen - 1'b1);

  for (genvar c = 0; c < CH; c++) begin : g_lane
    pe_lane #(.DW(DW), .KDEPTH(KDEPTH), .KW(KW), .ACCW(ACCW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (flt_we[c] & idle),
      .waddr (flt_addr),
      .wdata (flt_data),
      .clr   (clr),
      .en    (en),
      .k     (k),
      .pix   (pix[c]),
      .acc   (acc[c])
    );
  end

  // Channel sum at ACCW+clog2(CH) bits cannot overflow.
  always_comb begin
    total = '0;
    for (int c = 0; c < CH; c++) total = total + TW'(acc[c]);
  end

`ifdef PE_SAT_OUT_EN
  logic [TW-1:0] shifted;
  assign shifted = total >> OSHIFT;
  assign res = (shifted > TW'({DW{1'b1}})) ? {DW{1'b1}} : shifted[DW-1:0];
`else
  assign res = DW'(total >> OSHIFT);
`endif

  always_comb begin
    nxt = state;
    clr = 1'b0;
    en  = 1'b0;
    case (state)
      IDLE: if (start) begin
        clr = 1'b1;
        nxt = MAC;
      end
      MAC: if (win_valid) begin
        en = 1'b1;
        if (k == last_k) nxt = SUM;
      end
      SUM: nxt = OUT;
      OUT: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      k        <= '0;
      last_k   <= '0;
      out_data <= '0;
    end else begin
      state <= nxt;
      if (clr) begin
        k      <= '0;
        last_k <= klen_last;
      end else if (en) begin
        k <= k + 1'b1;
      end
      if (state == SUM) out_data <= res;
    end
  end
endmodule

// File: tb/tb_pe_multi_ch.sv
module tb_pe_multi_ch;
  localparam int CH = 4, DW = 8, KDEPTH = 16, ACCW = 20, OSHIFT = 4, KW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   flt_we;
  logic [KW-1:0]   flt_addr;
  logic [DW-1:0]   flt_data;
  logic [KW:0]     klen;
  logic            start, win_valid, win_ready, out_valid, out_ready, busy;
  logic [CH*DW-1:0] win_data;
  logic [DW-1:0]   out_data;

  int checks = 0;
  int errors = 0;

  pe_multi_ch #(.CH(CH), .DW(DW), .KDEPTH(KDEPTH), .ACCW(ACCW), .OSHIFT(OSHIFT)) dut (
    .clk(clk), .rst(rst), .flt_we(flt_we), .flt_addr(flt_addr), .flt_data(flt_data),
    .klen(klen), .start(start), .win_valid(win_valid), .win_data(win_data),
    .win_ready(win_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_all(input logic [DW-1:0] v);
    for (int a = 0; a < KDEPTH; a++) begin
      flt_we = '1; flt_addr = KW'(a); flt_data = v;
      tick();
    end
    flt_we = '0;
  endtask

  // Start an operation and stream beats until nb are accepted; gaps inserts
  // idle cycles on win_valid. Bounded by a cycle budget.
  task automatic run(input logic [KW:0] kl, input logic [DW-1:0] p, input int nb,
                     input bit gaps, input string tag);
    int acc_cnt = 0;
    int cyc = 0;
    klen = kl; start = 1'b1;
    tick();
    start = 1'b0;
    win_data = {CH{p}};
    while (acc_cnt < nb && cyc < 200) begin
      win_valid = gaps ? (cyc % 3 != 1) : 1'b1;
      if (win_valid && win_ready) acc_cnt++;
      tick();
      cyc++;
    end
    win_valid = 1'b0;
    chk({tag, "_beats"}, acc_cnt, nb);
  endtask

  task automatic wait_out(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < 10) begin tick(); cyc++; end
    chk({tag, "_valid"}, out_valid, 1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flt_we = '0; flt_addr = '0; flt_data = '0; klen = '0;
    start = 1'b0; win_valid = 1'b0; win_data = '0; out_ready = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_ready", win_ready, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_odata", out_data, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // All filters 1, pixels 2, klen 0 -> 16 beats, 4*32>>4 = 8, latency 2.
    load_all(8'd1);
    klen = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_ready", win_ready, 1);
    win_valid = 1'b1; win_data = {CH{8'd2}};
    for (int i = 0; i < 16; i++) tick();
    win_valid = 1'b0;
    chk("t1_lat1_valid", out_valid, 0);
    chk("t1_sum_ready", win_ready, 0);
    tick();
    chk("t1_lat2_valid", out_valid, 1);
    chk("t1_data", out_data, 8);
    consume();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_valid", out_valid, 0);

    // Max operands: 4*16*65025 = 4161600, >>4 = 260100.
    load_all(8'd255);
    run(5'd16, 8'd255, 16, 1'b0, "t2");
    wait_out("t2");
`ifdef PE_SAT_OUT_EN
    chk("t2_data", out_data, 255);
`else
    chk("t2_data", out_data, 4);
`endif
    consume();

    // klen 1, filter[c][0]=c+1, pixels 10 -> 100>>4 = 6; extra beats refused.
    for (int c = 0; c < CH; c++) begin
      flt_we = CH'(1 << c); flt_addr = '0; flt_data = DW'(c + 1);
      tick();
    end
    flt_we = '0;
    klen = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    win_valid = 1'b1; win_data = {CH{8'd10}};
    tick();
    chk("t3_sum_ready", win_ready, 0);
    tick();
    chk("t3_out_ready", win_ready, 0);
    chk("t3_valid", out_valid, 1);
    chk("t3_data", out_data, 6);
    win_valid = 1'b0;

    // Backpressure in OUT with start/flt_we pulses; start during handshake.
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      flt_we = (i == 2) ? '1 : '0; flt_addr = '0; flt_data = 8'd99;
      tick();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, 6);
    end
    flt_we = '0;
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_valid", out_valid, 0);
    tick();
    chk("t4_no_restart", busy, 0);
    // Filters must be untouched: same operation gives 6 again.
    run(5'd1, 8'd10, 1, 1'b0, "t4r");
    wait_out("t4r");
    chk("t4r_data", out_data, 6);
    consume();

    // Gapped stream gives the same result as back-to-back.
    load_all(8'd1);
    run(5'd0, 8'd2, 16, 1'b1, "t5");
    wait_out("t5");
    chk("t5_data", out_data, 8);
    consume();

    // Reset mid-MAC after 7 beats: outputs drop asynchronously.
    run(5'd0, 8'd2, 7, 1'b0, "t6");
    chk("t6_busy_pre", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_ready", win_ready, 0);
    chk("t6_ovalid", out_valid, 0);
    chk("t6_odata", out_data, 0);
    tick();
    rst = 1'b1;
    tick();
    // Filters were cleared by reset, so a fresh run yields 0.
    run(5'd0, 8'd2, 16, 1'b0, "t7");
    wait_out("t7");
    chk("t7_data", out_data, 0);
    consume();
    chk("t7_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
